// File: rtl/call_stack_unit.sv
// Return-address stack for the jump controller: JSB pushes PC+1, RTS pops it.
// Push together with pop replaces the top entry; misuse raises sticky error flags.
module call_stack_unit #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_stack,
    input  logic                     pop_stack,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic                     clear_err,
    output logic [ADDR_W-1:0]        top_addr,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     overflow_err,
    output logic                     underflow_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] mem;
    logic [SP_W-1:0]              sp, sp_nxt;
    logic [IDX_W-1:0]             top_idx, wr_idx;
    logic                         wr_en, ovf_ev, unf_ev;

    assign empty   = (sp == '0);
    assign full    = (sp == SP_W'(DEPTH));
    assign depth   = sp;
    assign top_idx = IDX_W'(sp - SP_W'(1));
    // Storage is never reset, so the output is masked while the stack is empty.
    assign top_addr = empty ? '0 : mem[top_idx];

    always_comb begin
        sp_nxt = sp;
        wr_en  = 1'b0;
        wr_idx = IDX_W'(sp);
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        unique case ({push_stack, pop_stack})
            2'b10: begin
                if (full) begin
                    ovf_ev = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    sp_nxt = sp + SP_W'(1);
                end
            end
            2'b01: begin
                if (empty) unf_ev = 1'b1;
                else       sp_nxt = sp - SP_W'(1);
            end
            2'b11: begin
                wr_en = 1'b1;
                if (empty) begin
                    // Pop half underflows, push half still lands in entry 0.
                    unf_ev = 1'b1;
                    wr_idx = '0;
                    sp_nxt = SP_W'(1);
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp            <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            sp            <= sp_nxt;
            overflow_err  <= ovf_ev | (overflow_err & ~clear_err);
            underflow_err <= unf_ev | (underflow_err & ~clear_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= push_addr;
    end
endmodule

// File: tb/tb_call_stack_unit.sv
// Bench for call_stack_unit: directed vector table, async-reset sequence,
// then random traffic against a queue-based stack model.
module tb_call_stack_unit;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              push_stack = 1'b0, pop_stack = 1'b0, clear_err = 1'b0;
    logic [ADDR_W-1:0] push_addr = '0;
    logic [ADDR_W-1:0] top_addr;
    logic              empty, full, overflow_err, underflow_err;
    logic [3:0]        depth;

    int n_cmp = 0;
    int n_bad = 0;

    call_stack_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .push_stack(push_stack), .pop_stack(pop_stack),
        .push_addr(push_addr), .clear_err(clear_err), .top_addr(top_addr),
        .empty(empty), .full(full), .depth(depth),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push, pop, clr;
        logic [11:0] addr;
        int          e_depth;
        logic [11:0] e_top;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_d, input int e_top,
                           input int e_ovf, input int e_unf);
        chk({tag, " depth"}, int'(depth), e_d);
        chk({tag, " top_addr"}, int'(top_addr), e_top);
        chk({tag, " empty"}, int'(empty), int'(e_d == 0));
        chk({tag, " full"}, int'(full), int'(e_d == DEPTH));
        chk({tag, " overflow_err"}, int'(overflow_err), e_ovf);
        chk({tag, " underflow_err"}, int'(underflow_err), e_unf);
    endtask

    task automatic step(input logic p, input logic q, input logic c, input logic [11:0] a);
        push_stack = p; pop_stack = q; clear_err = c; push_addr = a;
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic p, q, c, input logic [11:0] a,
                                input int d, input logic [11:0] t, input logic o, u);
        vec_t v;
        v.push = p; v.pop = q; v.clr = c; v.addr = a;
        v.e_depth = d; v.e_top = t; v.e_ovf = o; v.e_unf = u;
        return v;
    endfunction

    // Reference model: plain queue, top at the back.
    logic [11:0] mq[$];
    logic        m_ovf, m_unf;

    task automatic model_step(input logic p, q, c, input logic [11:0] a);
        logic ov, un;
        ov = 0; un = 0;
        if (p && q) begin
            if (mq.size() == 0) begin mq.push_back(a); un = 1; end
            else mq[mq.size()-1] = a;
        end else if (p) begin
            if (mq.size() == DEPTH) ov = 1;
            else mq.push_back(a);
        end else if (q) begin
            if (mq.size() == 0) un = 1;
            else void'(mq.pop_back());
        end
        m_ovf = ov | (m_ovf & ~c);
        m_unf = un | (m_unf & ~c);
    endtask

    initial begin
        // Directed vectors, each row = one cycle from a freshly reset stack.
        vecs.push_back(mk(1,0,0,12'h010, 1,12'h010,0,0));
        vecs.push_back(mk(1,0,0,12'h020, 2,12'h020,0,0));
        vecs.push_back(mk(1,0,0,12'h030, 3,12'h030,0,0));
        vecs.push_back(mk(0,1,0,12'h000, 2,12'h020,0,0));
        vecs.push_back(mk(0,1,0,12'h000, 1,12'h010,0,0));
        vecs.push_back(mk(0,1,0,12'h000, 0,12'h000,0,0));
        vecs.push_back(mk(0,1,0,12'h000, 0,12'h000,0,1));
        vecs.push_back(mk(0,0,1,12'h000, 0,12'h000,0,0));
        vecs.push_back(mk(1,1,0,12'h055, 1,12'h055,0,1));
        vecs.push_back(mk(0,0,1,12'h000, 1,12'h055,0,0));
        vecs.push_back(mk(0,1,0,12'h000, 0,12'h000,0,0));
        vecs.push_back(mk(0,1,1,12'h000, 0,12'h000,0,1));
        vecs.push_back(mk(0,0,1,12'h000, 0,12'h000,0,0));
        vecs.push_back(mk(1,0,0,12'h111, 1,12'h111,0,0));
        vecs.push_back(mk(1,1,0,12'h222, 1,12'h222,0,0));
        vecs.push_back(mk(0,0,0,12'hFFF, 1,12'h222,0,0));
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(1,0,0,12'(12'h300 + i), i+1, 12'(12'h300 + i),0,0));
        vecs.push_back(mk(1,1,0,12'h3AA, 8,12'h3AA,0,0));
        vecs.push_back(mk(1,0,0,12'hABC, 8,12'h3AA,1,0));
        for (int i = 6; i >= 1; i--)
            vecs.push_back(mk(0,1,0,12'h000, i+1, 12'(12'h300 + i),1,0));
        vecs.push_back(mk(0,1,0,12'h000, 1,12'h222,1,0));
        vecs.push_back(mk(0,1,0,12'h000, 0,12'h000,1,0));
        vecs.push_back(mk(0,0,1,12'h000, 0,12'h000,0,0));

        #2;
        chk_all("reset", 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].addr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_depth, int'(vecs[i].e_top),
                    int'(vecs[i].e_ovf), int'(vecs[i].e_unf));
        end

        // Async reset mid-operation with a sticky flag set and 5 entries.
        step(0,1,0,12'h000);
        for (int i = 0; i < 5; i++) step(1,0,0,12'(12'h500 + i));
        chk_all("pre_rst", 5, 12'h504, 0, 1);
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0);
        step(1,0,0,12'h6AA);
        chk_all("rst_ignores_push", 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        step(1,0,0,12'h777);
        chk_all("post_rst_push", 1, 12'h777, 0, 0);
        step(0,0,0,12'h000);

        // Random traffic against the queue model.
        mq.delete();
        mq.push_back(12'h777);
        m_ovf = 0; m_unf = 0;
        for (int n = 0; n < 400; n++) begin
            int r;
            logic p, q, c;
            logic [11:0] a;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                @(negedge clk); rst = 1'b1; #1 rst = 1'b0;
                mq.delete(); m_ovf = 0; m_unf = 0;
            end
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 40);
            c = ($urandom_range(0, 99) < 8);
            a = 12'($urandom);
            step(p, q, c, a);
            model_step(p, q, c, a);
            chk_all($sformatf("rnd%0d", n), mq.size(),
                    mq.size() == 0 ? 0 : int'(mq[mq.size()-1]), int'(m_ovf), int'(m_unf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
